// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/LS requesters, the memory port arbiter
// and the unified single-port memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store:
// one access at a time, LS priority with an IF anti-starvation override.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SV_W  = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LAT);
  localparam logic [SV_W-1:0]  STARVE_TOP = SV_W'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [SV_W-1:0]   r_starve;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner_ls;
  logic              r_we;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_ls_rvalid;
  logic [DATA_W-1:0] r_ls_rdata;

  logic w_idle;
  logic w_if_wins;
  logic w_if_gnt;
  logic w_ls_gnt;

  // Grants are masked while reset is held so nothing is accepted that reset would drop.
  assign w_idle    = (r_state == S_IDLE) && !reset;
  assign w_if_wins = bus.if_req && (!bus.ls_req || (r_starve == STARVE_TOP));
  assign w_if_gnt  = w_idle && w_if_wins;
  assign w_ls_gnt  = w_idle && bus.ls_req && !w_if_wins;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_starve    <= '0;
      r_cnt       <= '0;
      r_owner_ls  <= 1'b0;
      r_we        <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!bus.if_req || w_if_gnt) begin
            r_starve <= '0;
          end else if (w_ls_gnt && (r_starve != STARVE_TOP)) begin
            r_starve <= r_starve + SV_W'(1);
          end
          if (w_if_gnt || w_ls_gnt) begin
            r_owner_ls <= w_ls_gnt;
            r_we       <= w_ls_gnt && bus.ls_we;
            r_addr     <= w_ls_gnt ? bus.ls_addr : bus.if_addr;
            r_wdata    <= w_ls_gnt ? bus.ls_wdata : '0;
            r_mem_en   <= 1'b1;
            r_mem_we   <= w_ls_gnt && bus.ls_we;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= LAT_INIT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // Last wait cycle: memory data is valid now, so it goes straight to the owner.
          if (r_cnt == CNT_W'(1)) begin
            if (r_owner_ls) begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= r_we ? '0 : bus.mem_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= bus.mem_rdata;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ls_gnt    = w_ls_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=1 instance driven through a
// response scoreboard, plus a MEM_LAT=3 instance for latency timing.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A), .STARVE_MAX(4)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_B), .STARVE_MAX(4)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave)
  );

  // Memory model: preset pattern, overwritten by stores; data only valid in the latency cycle.
  logic [31:0] mem_wr [256];
  logic        mem_wv [256];

  function automatic logic [31:0] pat(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]} ^ 32'h3C00_00A5;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_wv[a[7:0]] ? mem_wr[a[7:0]] : pat(a);
  endfunction

  logic        a_v;
  logic [31:0] a_d;
  always @(posedge clk) begin
    a_v <= a_if.mem_en;
    a_d <= rd(a_if.mem_addr);
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_wv[i] <= 1'b0;
    end else if (a_if.mem_en && a_if.mem_we) begin
      mem_wr[a_if.mem_addr[7:0]] <= a_if.mem_wdata;
      mem_wv[a_if.mem_addr[7:0]] <= 1'b1;
    end
  end
  assign a_if.mem_rdata = a_v ? a_d : 32'hBAD0_BAD0;

  logic [2:0]  b_v;
  logic [31:0] b_d [3];
  always @(posedge clk) begin
    b_v    <= {b_v[1:0], b_if.mem_en};
    b_d[0] <= pat(b_if.mem_addr);
    b_d[1] <= b_d[0];
    b_d[2] <= b_d[1];
  end
  assign b_if.mem_rdata = b_v[2] ? b_d[2] : 32'hBAD0_BAD0;

  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;
  exp_t if_q[$];
  exp_t ls_q[$];
  int   gseq[$];
  bit   if_hold = 0, ls_hold = 0, if_drop = 0, ls_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic resp_check();
    exp_t e;
    if (a_if.if_rvalid) begin
      chk("if_rvalid_expected", 32'(if_q.size() != 0), 32'd1);
      if (if_q.size() != 0) begin
        e = if_q.pop_front();
        chk("if_rdata", a_if.if_rdata, e.data);
        chk("if_rvalid_cycle", cyc_n, e.cyc);
      end
    end else if (if_q.size() != 0 && if_q[0].cyc <= cyc_n) begin
      chk("if_rvalid_missing", 32'(a_if.if_rvalid), 32'd1);
      void'(if_q.pop_front());
    end
    if (a_if.ls_rvalid) begin
      chk("ls_rvalid_expected", 32'(ls_q.size() != 0), 32'd1);
      if (ls_q.size() != 0) begin
        e = ls_q.pop_front();
        chk("ls_rdata", a_if.ls_rdata, e.data);
        chk("ls_rvalid_cycle", cyc_n, e.cyc);
      end
    end else if (ls_q.size() != 0 && ls_q[0].cyc <= cyc_n) begin
      chk("ls_rvalid_missing", 32'(a_if.ls_rvalid), 32'd1);
      void'(ls_q.pop_front());
    end
  endtask

  // Clock edge + 1: check registered outputs, release one-shot requests.
  task automatic tick();
    @(posedge clk);
    cyc_n++;
    #1;
    resp_check();
    if (if_drop) begin a_if.if_req = 1'b0; if_drop = 0; end
    if (ls_drop) begin a_if.ls_req = 1'b0; ls_drop = 0; end
  endtask

  // Falling edge: grants are stable; push the expected response for each.
  task automatic samp();
    exp_t e;
    @(negedge clk);
    chk("single_gnt", 32'(a_if.if_gnt & a_if.ls_gnt), 32'd0);
    if (a_if.if_gnt) begin
      e.data = rd(a_if.if_addr);
      e.cyc  = cyc_n + 2 + LAT_A;
      if_q.push_back(e);
      gseq.push_back(0);
      if (!if_hold) if_drop = 1;
    end
    if (a_if.ls_gnt) begin
      e.data = a_if.ls_we ? 32'd0 : rd(a_if.ls_addr);
      e.cyc  = cyc_n + 2 + LAT_A;
      ls_q.push_back(e);
      gseq.push_back(1);
      if (!ls_hold) ls_drop = 1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin tick(); samp(); end
  endtask

  task automatic drain();
    int k = 0;
    while ((if_q.size() != 0 || ls_q.size() != 0) && k < 40) begin
      run(1);
      k++;
    end
    chk("drain_timeout", 32'(if_q.size() + ls_q.size()), 32'd0);
    if_q.delete();
    ls_q.delete();
  endtask

  task automatic chk_all_zero(input string t);
    chk({t, ".if_gnt"},    32'(a_if.if_gnt),    32'd0);
    chk({t, ".if_rvalid"}, 32'(a_if.if_rvalid), 32'd0);
    chk({t, ".if_rdata"},  a_if.if_rdata,       32'd0);
    chk({t, ".ls_gnt"},    32'(a_if.ls_gnt),    32'd0);
    chk({t, ".ls_rvalid"}, 32'(a_if.ls_rvalid), 32'd0);
    chk({t, ".ls_rdata"},  a_if.ls_rdata,       32'd0);
    chk({t, ".mem_en"},    32'(a_if.mem_en),    32'd0);
    chk({t, ".mem_we"},    32'(a_if.mem_we),    32'd0);
    chk({t, ".mem_addr"},  a_if.mem_addr,       32'd0);
    chk({t, ".mem_wdata"}, a_if.mem_wdata,      32'd0);
    chk({t, ".busy"},      32'(a_if.busy),      32'd0);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    a_if.if_req = 0; a_if.if_addr = '0; a_if.ls_req = 0; a_if.ls_we = 0;
    a_if.ls_addr = '0; a_if.ls_wdata = '0;
    b_if.if_req = 0; b_if.if_addr = '0; b_if.ls_req = 0; b_if.ls_we = 0;
    b_if.ls_addr = '0; b_if.ls_wdata = '0;
    run(3);

    // Reset state
    tick();
    chk_all_zero("rst");
    chk("rst.b_busy", 32'(b_if.busy), 32'd0);
    reset = 1'b0;
    samp();
    run(2);

    // 1: single fetch
    tick(); a_if.if_req = 1; a_if.if_addr = 32'h10; samp();
    chk("t1.if_gnt", 32'(a_if.if_gnt), 32'd1);
    chk("t1.ls_gnt", 32'(a_if.ls_gnt), 32'd0);
    tick();
    chk("t1.mem_en", 32'(a_if.mem_en), 32'd1);
    chk("t1.mem_we", 32'(a_if.mem_we), 32'd0);
    chk("t1.mem_addr", a_if.mem_addr, 32'h10);
    chk("t1.mem_wdata", a_if.mem_wdata, 32'd0);
    chk("t1.busy1", 32'(a_if.busy), 32'd1);
    samp();
    tick(); chk("t1.busy2", 32'(a_if.busy), 32'd1); chk("t1.mem_en_off", 32'(a_if.mem_en), 32'd0); samp();
    tick(); chk("t1.if_rvalid", 32'(a_if.if_rvalid), 32'd1); chk("t1.busy3", 32'(a_if.busy), 32'd1); samp();
    tick(); chk("t1.busy4", 32'(a_if.busy), 32'd0); chk("t1.rdata_hold", a_if.if_rdata, 32'hDEAD_BEEF); samp();
    drain();

    // 2: simultaneous requests, LS first
    tick();
    gseq.delete();
    a_if.if_req = 1; a_if.if_addr = 32'h30;
    a_if.ls_req = 1; a_if.ls_we = 0; a_if.ls_addr = 32'h20;
    samp();
    chk("t2.ls_gnt", 32'(a_if.ls_gnt), 32'd1);
    chk("t2.if_gnt0", 32'(a_if.if_gnt), 32'd0);
    run(3);
    chk("t2.ls_rvalid", 32'(a_if.ls_rvalid), 32'd1);
    chk("t2.if_rvalid0", 32'(a_if.if_rvalid), 32'd0);
    run(1);
    chk("t2.if_gnt4", 32'(a_if.if_gnt), 32'd1);
    drain();
    chk("t2.order_n", 32'(gseq.size()), 32'd2);
    if (gseq.size() == 2) begin
      chk("t2.order0", gseq[0], 32'd1);
      chk("t2.order1", gseq[1], 32'd0);
    end

    // 3: store, then read it back
    tick(); a_if.ls_req = 1; a_if.ls_we = 1; a_if.ls_addr = 32'h40; a_if.ls_wdata = 32'h1234_5678; samp();
    chk("t3.ls_gnt", 32'(a_if.ls_gnt), 32'd1);
    tick();
    chk("t3.mem_en", 32'(a_if.mem_en), 32'd1);
    chk("t3.mem_we", 32'(a_if.mem_we), 32'd1);
    chk("t3.mem_addr", a_if.mem_addr, 32'h40);
    chk("t3.mem_wdata", a_if.mem_wdata, 32'h1234_5678);
    samp();
    tick();
    chk("t3.mem_en_off", 32'(a_if.mem_en), 32'd0);
    chk("t3.mem_we_off", 32'(a_if.mem_we), 32'd0);
    chk("t3.addr_hold", a_if.mem_addr, 32'h40);
    samp();
    drain();
    tick(); a_if.ls_req = 1; a_if.ls_we = 0; a_if.ls_addr = 32'h40; samp();
    chk("t3.rb_gnt", 32'(a_if.ls_gnt), 32'd1);
    drain();

    // 4: starvation with both requests held
    tick();
    gseq.delete();
    if_hold = 1; ls_hold = 1;
    a_if.if_req = 1; a_if.if_addr = 32'h60;
    a_if.ls_req = 1; a_if.ls_we = 0; a_if.ls_addr = 32'h50;
    samp();
    k = 0;
    while (gseq.size() < 10 && k < 80) begin run(1); k++; end
    tick(); a_if.if_req = 0; a_if.ls_req = 0; if_hold = 0; ls_hold = 0; samp();
    drain();
    chk("t4.arb_count", 32'(gseq.size()), 32'd10);
    for (int i = 0; i < 10 && i < gseq.size(); i++)
      chk($sformatf("t4.arb%0d", i), gseq[i], (i == 4 || i == 9) ? 32'd0 : 32'd1);

    // 5: reset during WAIT
    tick();
    gseq.delete();
    if_hold = 1; ls_hold = 1;
    a_if.ls_req = 1; a_if.ls_we = 0; a_if.ls_addr = 32'h70;
    a_if.if_req = 1; a_if.if_addr = 32'h74;
    samp();
    chk("t5.ls_gnt", 32'(a_if.ls_gnt), 32'd1);
    run(1);
    tick(); chk("t5.in_wait", 32'(a_if.busy), 32'd1); reset = 1; if_q.delete(); ls_q.delete(); samp();
    tick(); chk_all_zero("t5"); samp();
    tick(); reset = 0; if_hold = 0; ls_hold = 0; gseq.delete(); samp();
    chk("t5.ls_first", 32'(a_if.ls_gnt), 32'd1);
    chk("t5.if_waits", 32'(a_if.if_gnt), 32'd0);
    run(2);
    drain();
    run(2);
    drain();
    chk("t5.order_n", 32'(gseq.size()), 32'd2);
    if (gseq.size() == 2) begin
      chk("t5.order0", gseq[0], 32'd1);
      chk("t5.order1", gseq[1], 32'd0);
    end

    // 6: MEM_LAT=3 load timing on the second instance
    tick(); b_if.ls_req = 1; b_if.ls_we = 0; b_if.ls_addr = 32'h80; samp();
    chk("t6.gnt0", 32'(b_if.ls_gnt), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("t6.mem_en%0d", i), 32'(b_if.mem_en), (i == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t6.rvalid%0d", i), 32'(b_if.ls_rvalid), (i == 5) ? 32'd1 : 32'd0);
      chk($sformatf("t6.busy%0d", i), 32'(b_if.busy), 32'd1);
      if (i == 5) begin
        chk("t6.rdata", b_if.ls_rdata, pat(32'h80));
        chk("t6.if_rvalid", 32'(b_if.if_rvalid), 32'd0);
      end
      samp();
      chk($sformatf("t6.nogrant%0d", i), 32'(b_if.ls_gnt), 32'd0);
    end
    tick(); chk("t6.idle6", 32'(b_if.busy), 32'd0); samp();
    chk("t6.next_gnt6", 32'(b_if.ls_gnt), 32'd1);
    tick(); b_if.ls_req = 0; samp();
    run(8);
    chk("end.a_idle", 32'(a_if.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
